// File: rtl/id_issue_ctrl.sv
// Decode/issue stage: one-entry output register behind a valid/ready
// handshake, a per-register pending-write scoreboard that stalls RAW and
// WAW hazards, branch-delay-slot tagging and reserved-instruction carry.
//
// Handshake semantics (both sides): a transfer happens on a rising clock
// edge where valid & ready are both high. A producer holding valid high
// keeps its payload stable until the transfer; ready never depends on
// valid on the same interface.
module id_issue_ctrl #(
    parameter int PC_W    = 32,
    parameter int RA_W    = 5,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 32
) (
    input  logic               clk,
    input  logic               resetn,

    // upstream (fetch) side
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               in_ra_en,
    input  logic [RA_W-1:0]    in_ra_addr,
    input  logic               in_rb_en,
    input  logic [RA_W-1:0]    in_rb_addr,
    input  logic               in_wr_en,
    input  logic [RA_W-1:0]    in_wr_addr,
    input  logic               in_jump,
    input  logic               in_resv,

    // downstream (execute) side
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic [PC_W-1:0]    out_pc,
    output logic               out_wr_en,
    output logic [RA_W-1:0]    out_wr_addr,
    output logic               out_bd,
    output logic               out_exc_ri,

    // writeback retire
    input  logic               wb_valid,
    input  logic [RA_W-1:0]    wb_addr,

    // exception entry / eret
    input  logic               flush,

    // status
    output logic               sb_err,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam int               NREG    = 1 << RA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [RA_W-1:0]  REG_0   = '0;

    // Pending-write counters, one per architectural register. Entry 0 is
    // never incremented or decremented and therefore stays at zero.
    logic [CNT_W-1:0] cnt [NREG];

    // Set when the last issued instruction was a branch/jump, so the next
    // one to issue is its delay slot.
    logic bd_pending;

    logic we;
    logic ra_hazard;
    logic rb_hazard;
    logic wr_hazard;
    logic hazard;
    logic issue;
    logic drain;
    logic retire;
    logic retire_zero;

    // Hazard detection from counter values registered at cycle start, so a
    // retire in this cycle only unblocks a dependent instruction next cycle.
    always_comb begin
        we        = in_wr_en & ~in_resv & (in_wr_addr != REG_0);
        ra_hazard = in_ra_en & (in_ra_addr != REG_0) & (cnt[in_ra_addr] != '0);
        rb_hazard = in_rb_en & (in_rb_addr != REG_0) & (cnt[in_rb_addr] != '0);
        wr_hazard = we & (cnt[in_wr_addr] == CNT_MAX);
        hazard    = ra_hazard | rb_hazard | wr_hazard;
        in_ready  = ~flush & ~hazard & (~out_valid | out_ready);
    end

    // Transfer and retire qualifiers shared by the sequential blocks.
    always_comb begin
        issue       = in_valid & in_ready;
        drain       = out_valid & out_ready;
        retire      = wb_valid & (wb_addr != REG_0);
        retire_zero = retire & (cnt[wb_addr] == '0);
    end

    // Output register: load on issue, clear on drain, killed by flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid   <= 1'b0;
            out_inst    <= '0;
            out_pc      <= '0;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
            out_bd      <= 1'b0;
            out_exc_ri  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid   <= 1'b1;
            out_inst    <= in_inst;
            out_pc      <= in_pc;
            out_wr_en   <= we;
            out_wr_addr <= in_wr_addr;
            out_bd      <= bd_pending;
            out_exc_ri  <= in_resv;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // Delay-slot tracker: only an issue or a flush changes it, so it
    // survives any number of stall cycles between a branch and its slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bd_pending <= 1'b0;
        end else if (flush) begin
            bd_pending <= 1'b0;
        end else if (issue) begin
            bd_pending <= in_jump;
        end
    end

    // Scoreboard counters: +1 on issue of a tracked write, -1 on retire,
    // unchanged when both hit the same register; a retire at zero holds 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if ((issue & we & (in_wr_addr == RA_W'(i))) &&
                    !(retire & (wb_addr == RA_W'(i)))) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (!(issue & we & (in_wr_addr == RA_W'(i))) &&
                             (retire & (wb_addr == RA_W'(i))) &&
                             (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // Sticky scoreboard error: a retire for a register with nothing pending.
    // A flush suppresses the same-cycle retire, so it cannot set this flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_err <= 1'b0;
        end else if (!flush && retire_zero) begin
            sb_err <= 1'b1;
        end
    end

    // Saturating count of cycles where an offered instruction was held off.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
